// File: rtl/iodelay_train.sv
// Tap-training controller for one MIPI data lane IO delay line.
// Sweeps every tap, counts training-byte matches in a fixed window per tap,
// tracks the widest run of passing taps and writes its centre as the final tap.
module iodelay_train #(
  parameter int         P_DELAY_NBIT  = 5,
  parameter int         P_DEFAULT_TAP = 16,
  parameter int         P_SETTLE_CYC  = 40,
  parameter int         P_SAMPLE_CYC  = 64,
  parameter logic [7:0] P_PATTERN     = 8'hB8,
  parameter int         P_MIN_HITS    = 6,
  parameter int         P_MIN_EYE     = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_start,
  input  logic                    in_dio,
  output logic [P_DELAY_NBIT-1:0] out_delay,
  output logic                    out_delay_we,
  output logic                    out_busy,
  output logic                    out_done,
  output logic                    out_fail,
  output logic [P_DELAY_NBIT-1:0] out_eye_left,
  output logic [P_DELAY_NBIT:0]   out_eye_width
);

  localparam int TW      = P_DELAY_NBIT;
  localparam int LW      = P_DELAY_NBIT + 1;
  localparam int CNT_MAX = (P_SETTLE_CYC > P_SAMPLE_CYC) ? P_SETTLE_CYC : P_SAMPLE_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(P_SAMPLE_CYC + 1);

  localparam logic [TW-1:0] LAST_TAP    = {TW{1'b1}};
  localparam logic [TW-1:0] DEF_TAP     = TW'(P_DEFAULT_TAP);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(P_SETTLE_CYC - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(P_SAMPLE_CYC - 1);
  localparam logic [HW-1:0] HIT_MAX     = HW'(P_SAMPLE_CYC);
  localparam logic [HW-1:0] MIN_HITS    = HW'(P_MIN_HITS);
  localparam logic [LW-1:0] MIN_EYE     = LW'(P_MIN_EYE);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_EVAL   = 3'd4;
  localparam logic [2:0] S_FINAL  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hits_q, hits_d;
  logic [7:0]    sr_q, sr_d;
  logic [LW-1:0] cur_len_q, cur_len_d, best_len_q, best_len_d;
  logic [TW-1:0] cur_left_q, cur_left_d, best_left_q, best_left_d;
  logic [TW-1:0] delay_q, delay_d;
  logic          we_q, we_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d;
  logic [TW-1:0] eye_left_q, eye_left_d;
  logic [LW-1:0] eye_width_q, eye_width_d;
  logic [LW-1:0] upd_len;
  logic [TW-1:0] upd_left;

  // Sweep sequencing, window tracking and output selection.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    cnt_d       = cnt_q;
    hits_d      = hits_q;
    sr_d        = {sr_q[6:0], in_dio};
    cur_len_d   = cur_len_q;
    cur_left_d  = cur_left_q;
    best_len_d  = best_len_q;
    best_left_d = best_left_q;
    delay_d     = delay_q;
    we_d        = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    fail_d      = fail_q;
    eye_left_d  = eye_left_q;
    eye_width_d = eye_width_q;
    upd_len     = cur_len_q;
    upd_left    = cur_left_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (in_start) begin
          tap_d       = '0;
          best_len_d  = '0;
          best_left_d = '0;
          cur_len_d   = '0;
          cur_left_d  = '0;
          done_d      = 1'b0;
          fail_d      = 1'b0;
          busy_d      = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        delay_d = tap_q;
        we_d    = 1'b1;
        sr_d    = '0;
        hits_d  = '0;
        cnt_d   = '0;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (sr_q == P_PATTERN && hits_q != HIT_MAX) hits_d = hits_q + 1'b1;
        if (cnt_q == SAMPLE_LAST) state_d = S_EVAL;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      S_EVAL: begin
        if (hits_q >= MIN_HITS) begin
          if (cur_len_q == '0) upd_left = tap_q;
          upd_len = cur_len_q + 1'b1;
        end else begin
          upd_len = '0;
        end
        cur_len_d  = upd_len;
        cur_left_d = upd_left;
        // Strict compare keeps the earliest of equally wide windows.
        if (upd_len > best_len_q) begin
          best_len_d  = upd_len;
          best_left_d = upd_left;
        end
        if (tap_q == LAST_TAP) begin
          state_d = S_FINAL;
        end else begin
          tap_d   = tap_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_FINAL: begin
        if (best_len_q >= MIN_EYE) begin
          delay_d = TW'({1'b0, best_left_q} + ((best_len_q - 1'b1) >> 1));
        end else begin
          delay_d = DEF_TAP;
          fail_d  = 1'b1;
        end
        we_d        = 1'b1;
        eye_left_d  = best_left_q;
        eye_width_d = best_len_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and lane-facing outputs; reset aborts any sweep immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      delay_q     <= DEF_TAP;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      eye_left_q  <= '0;
      eye_width_q <= '0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      eye_left_q  <= eye_left_d;
      eye_width_q <= eye_width_d;
    end
  end

  // Sweep datapath; every field is reinitialised by start or LOAD before use.
  always_ff @(posedge clk) begin
    tap_q       <= tap_d;
    cnt_q       <= cnt_d;
    hits_q      <= hits_d;
    sr_q        <= sr_d;
    cur_len_q   <= cur_len_d;
    cur_left_q  <= cur_left_d;
    best_len_q  <= best_len_d;
    best_left_q <= best_left_d;
  end

  assign out_delay     = delay_q;
  assign out_delay_we  = we_q;
  assign out_busy      = busy_q;
  assign out_done      = done_q;
  assign out_fail      = fail_q;
  assign out_eye_left  = eye_left_q;
  assign out_eye_width = eye_width_q;

endmodule

// File: tb/tb_iodelay_train.sv
// Directed bench for iodelay_train with a behavioural IO delay line model.
module tb_iodelay_train;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_start;
  logic       in_dio;
  logic [4:0] out_delay;
  logic       out_delay_we;
  logic       out_busy;
  logic       out_done;
  logic       out_fail;
  logic [4:0] out_eye_left;
  logic [5:0] out_eye_width;

  int errors = 0;
  int checks = 0;

  iodelay_train dut (
    .clk          (clk),
    .rst          (rst),
    .in_start     (in_start),
    .in_dio       (in_dio),
    .out_delay    (out_delay),
    .out_delay_we (out_delay_we),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_fail     (out_fail),
    .out_eye_left (out_eye_left),
    .out_eye_width(out_eye_width)
  );

  always #5 clk = ~clk;

  // Delay line model. mode per tap: 8 = clean repeating 8'hB8,
  // 0..7 = exactly that many aligned pattern bytes then zeros, 99 = random.
  // The line outputs zeros for 32 cycles after every tap write.
  int         mode [32];
  logic [4:0] mtap = '0;
  int         mcnt = 0;

  function automatic logic line_bit(input int m, input int c);
    logic [7:0] p;
    p = 8'hB8;
    if (c < 32) return 1'b0;
    if (m == 99) return 1'($urandom_range(0, 1));
    if (m == 8 || c < 32 + 8 * m) return p[7 - (c % 8)];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (out_delay_we) begin
      mtap = out_delay;
      mcnt = 0;
    end else begin
      mcnt = mcnt + 1;
    end
    in_dio = line_bit(mode[mtap], mcnt);
  end

  task automatic set_modes(input int dflt, input int lo, input int hi, input int val);
    for (int i = 0; i < 32; i++) mode[i] = (i >= lo && i <= hi) ? val : dflt;
  endtask

  task automatic add_modes(input int lo, input int hi, input int val);
    for (int i = lo; i <= hi; i++) mode[i] = val;
  endtask

  // Pulses start, follows the sweep until done (bounded) and records the writes.
  task automatic run_sweep(input int poke_at, output int ncyc, output int nwe,
                           output int seq_err, output logic [4:0] last_we,
                           output logic b1, output logic d1, output logic f1);
    @(negedge clk); in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    ncyc = 1; nwe = 0; seq_err = 0; last_we = '0;
    b1 = out_busy; d1 = out_done; f1 = out_fail;
    while (!out_done && ncyc < 4000) begin
      @(negedge clk);
      ncyc++;
      in_start = (ncyc == poke_at);
      if (out_delay_we) begin
        if (nwe < 32 && out_delay !== 5'(nwe)) seq_err++;
        last_we = out_delay;
        nwe++;
      end
    end
    in_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_start = 1'b0;
    repeat (3) @(negedge clk);
    if (out_delay !== 5'd16) begin errors++; $display("FAIL reset_delay got=%0d exp=16", out_delay); end
    checks++;
    if (out_delay_we !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", out_delay_we); end
    checks++;
    if ({out_busy, out_done, out_fail} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {out_busy, out_done, out_fail});
    end
    checks++;
    if (out_eye_left !== 5'd0 || out_eye_width !== 6'd0) begin
      errors++; $display("FAIL reset_eye got=%0d/%0d exp=0/0", out_eye_left, out_eye_width);
    end
    checks++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_eye;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 10, 17, 8);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (b1 !== 1'b1 || d1 !== 1'b0) begin errors++; $display("FAIL basic_busy_start got=%b%b exp=10", b1, d1); end
    checks++;
    if (n !== 3394) begin errors++; $display("FAIL basic_done_cycle got=%0d exp=3394", n); end
    checks++;
    if (nwe !== 33) begin errors++; $display("FAIL basic_we_count got=%0d exp=33", nwe); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL basic_tap_seq bad=%0d exp=0", se); end
    checks++;
    if (lw !== 5'd13) begin errors++; $display("FAIL basic_final_tap got=%0d exp=13", lw); end
    checks++;
    if (out_eye_left !== 5'd10 || out_eye_width !== 6'd8) begin
      errors++; $display("FAIL basic_eye got=%0d/%0d exp=10/8", out_eye_left, out_eye_width);
    end
    checks++;
    if ({out_fail, out_busy} !== 2'b00 || out_delay !== 5'd13) begin
      errors++; $display("FAIL basic_status got=%b%b/%0d exp=00/13", out_fail, out_busy, out_delay);
    end
    checks++;
    @(negedge clk);
    if (out_done !== 1'b1 || out_delay_we !== 1'b0) begin
      errors++; $display("FAIL basic_done_hold got=%b%b exp=10", out_done, out_delay_we);
    end
    checks++;
  endtask

  task automatic test_two_windows;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 2, 4, 8);
    add_modes(20, 25, 8);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (d1 !== 1'b0) begin errors++; $display("FAIL two_done_cleared got=%b exp=0", d1); end
    checks++;
    if (lw !== 5'd22 || out_eye_left !== 5'd20 || out_eye_width !== 6'd6 || out_fail !== 1'b0) begin
      errors++; $display("FAIL two_windows got=%0d/%0d/%0d/%b exp=22/20/6/0", lw, out_eye_left, out_eye_width, out_fail);
    end
    checks++;
  endtask

  task automatic test_equal_windows;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 4, 7, 8);
    add_modes(12, 15, 8);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (lw !== 5'd5 || out_eye_left !== 5'd4 || out_eye_width !== 6'd4) begin
      errors++; $display("FAIL equal_windows got=%0d/%0d/%0d exp=5/4/4", lw, out_eye_left, out_eye_width);
    end
    checks++;
  endtask

  task automatic test_all_clean;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(8, 0, 31, 8);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (lw !== 5'd15 || out_eye_left !== 5'd0 || out_eye_width !== 6'd32 || out_fail !== 1'b0) begin
      errors++; $display("FAIL all_clean got=%0d/%0d/%0d/%b exp=15/0/32/0", lw, out_eye_left, out_eye_width, out_fail);
    end
    checks++;
  endtask

  task automatic test_no_eye;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 0, 31, 99);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (lw !== 5'd16 || out_eye_width !== 6'd0 || out_fail !== 1'b1 || out_done !== 1'b1) begin
      errors++; $display("FAIL no_eye got=%0d/%0d/%b/%b exp=16/0/1/1", lw, out_eye_width, out_fail, out_done);
    end
    checks++;
  endtask

  task automatic test_five_hits;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(5, 0, 31, 5);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (lw !== 5'd16 || out_eye_width !== 6'd0 || out_fail !== 1'b1) begin
      errors++; $display("FAIL five_hits got=%0d/%0d/%b exp=16/0/1", lw, out_eye_width, out_fail);
    end
    checks++;
  endtask

  task automatic test_six_hits;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(5, 8, 11, 6);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (f1 !== 1'b0) begin errors++; $display("FAIL six_fail_cleared got=%b exp=0", f1); end
    checks++;
    if (lw !== 5'd9 || out_eye_left !== 5'd8 || out_eye_width !== 6'd4 || out_fail !== 1'b0) begin
      errors++; $display("FAIL six_hits got=%0d/%0d/%0d/%b exp=9/8/4/0", lw, out_eye_left, out_eye_width, out_fail);
    end
    checks++;
  endtask

  task automatic test_start_ignored;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 10, 17, 8);
    run_sweep(500, n, nwe, se, lw, b1, d1, f1);
    if (n !== 3394 || nwe !== 33 || se !== 0) begin
      errors++; $display("FAIL start_ignored got=%0d/%0d/%0d exp=3394/33/0", n, nwe, se);
    end
    checks++;
    if (lw !== 5'd13) begin errors++; $display("FAIL start_ignored_tap got=%0d exp=13", lw); end
    checks++;
  endtask

  task automatic test_reset_mid;
    int stray;
    set_modes(99, 10, 17, 8);
    @(negedge clk); in_start = 1'b1;
    @(negedge clk); in_start = 1'b0;
    repeat (368) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if (out_delay !== 5'd16 || out_delay_we !== 1'b0) begin
      errors++; $display("FAIL rst_mid_delay got=%0d/%b exp=16/0", out_delay, out_delay_we);
    end
    checks++;
    if ({out_busy, out_done, out_fail} !== 3'b000 || out_eye_left !== 5'd0 || out_eye_width !== 6'd0) begin
      errors++; $display("FAIL rst_mid_outputs got=%b/%0d/%0d exp=000/0/0",
                         {out_busy, out_done, out_fail}, out_eye_left, out_eye_width);
    end
    checks++;
    stray = 0;
    repeat (300) begin
      @(negedge clk);
      if (out_delay_we || out_busy) stray++;
    end
    if (stray !== 0) begin errors++; $display("FAIL rst_mid_quiet got=%0d exp=0", stray); end
    checks++;
  endtask

  task automatic test_back_to_back;
    int n, nwe, se; logic [4:0] lw; logic b1, d1, f1;
    set_modes(99, 2, 4, 8);
    add_modes(20, 25, 8);
    run_sweep(0, n, nwe, se, lw, b1, d1, f1);
    if (n !== 3394 || se !== 0 || lw !== 5'd22) begin
      errors++; $display("FAIL back_to_back got=%0d/%0d/%0d exp=3394/0/22", n, se, lw);
    end
    checks++;
  endtask

  initial begin
    in_start = 1'b0;
    set_modes(0, 0, 31, 0);
    test_reset();
    test_basic_eye();
    test_two_windows();
    test_equal_windows();
    test_all_clean();
    test_no_eye();
    test_five_hits();
    test_six_hits();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
